vga_fifo_scanout: RTL and testbench
===================================

Name: vga_fifo_scanout

Overview:
- Pixel-clock VGA scan-out stage directly downstream of the SDRAM-to-VGA-FIFO loader.
- Generates 1280x1024@60 timing and pulls one 8-bit grayscale byte per active pixel from the VGA FIFO (show-ahead, written by the loader).
- Drives the DAC (R=G=B=byte).
- Issues the per-line load requests (line number + request level) that trigger the loader one line ahead.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch (H_TOTAL = 1688)
- V_ACTIVE, 1024, active lines
- V_FP, 1, vertical front porch
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch (V_TOTAL = 1066)
- SYNC_POL, 1'b1, active level of HS/VS
- REQ_LEN, 4, cycles oLOAD_TO_FIFO_REQ is held high (covers the loader's 2-flop sampling in its own clock)

Ports:
- clock  in  1  pixel clock, 108 MHz
- iRST  in  1  asynchronous, active-high reset
- iFIFO_EMPTY  in  1  VGA FIFO empty
- iFIFO_RDATA  in  8  VGA FIFO head byte (show-ahead)
- oFIFO_RDREQ  out  1  pop head byte this cycle
- oLINE_TO_LOAD  out  13  line index for the loader, stable between requests
- oLOAD_TO_FIFO_REQ  out  1  load request level
- oFRAME_START  out  1  one-cycle pulse at frame boundary
- oVGA_CLK  out  1  = ~clock
- oVGA_R / oVGA_G / oVGA_B  out  8 each  pixel value
- oVGA_HS, oVGA_VS  out  1  syncs
- oVGA_BLANK_N  out  1  high during active video
- oVGA_SYNC_N  out  1  constant 0
- oUNDERFLOW  out  1  sticky: FIFO empty during an active pixel
- oSTALE  out  1  sticky: leftover bytes drained in vertical blank

Behaviour:
- Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 (11 bits each).
  - v_cnt increments when h_cnt wraps to 0; v_cnt wraps V_TOTAL-1 -> 0.
- Reset (async): h_cnt=0, v_cnt=VBP0 (= V_ACTIVE+V_FP+V_SYNC = 1028, first back-porch line).
  - All outputs 0, except HS/VS = ~SYNC_POL.
  - oLINE_TO_LOAD=0; request counter 0; sticky flags cleared.
- Region decode from registered counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
- FIFO read (combinational):
  - oFIFO_RDREQ = !iFIFO_EMPTY && (active || drain)
  - drain = V_ACTIVE <= v_cnt < VBP0
- Output register, latency 1 cycle from counter state, all aligned:
  - RGB <= (active && !iFIFO_EMPTY) ? iFIFO_RDATA : 0
  - HS/VS <= SYNC_POL when in region, else ~SYNC_POL
  - BLANK_N <= active
- Underflow: active && iFIFO_EMPTY -> black pixel, no pop, oUNDERFLOW set. Sticky until iRST; timing continues unaffected.
- Drain: any pop while drain=1 sets oSTALE (sticky until iRST). This resynchronises the FIFO once per frame before line 0 is requested.
- Requests, evaluated at h_cnt==H_ACTIVE (start of horizontal blank):
  - v_cnt < V_ACTIVE-1 -> request line v_cnt+1.
  - No request on lines V_ACTIVE-1..VBP0-1.
- Line-0 request and frame start, at v_cnt==VBP0 and h_cnt==0:
  - oFRAME_START pulses 1 cycle.
  - Line-0 request issued in the same cycle.
- Request mechanics:
  - oLINE_TO_LOAD <= target line on the issue cycle; held until the next issue.
  - oLOAD_TO_FIFO_REQ goes high the same cycle and stays high exactly REQ_LEN cycles.
  - A new issue while the request is still high restarts the count; unreachable with the default timing.
- Width rules:
  - v_cnt+1 computed in 11 bits, zero-extended to 13.
  - Comparisons are unsigned.
- Reset mid-frame: everything returns to the reset state. Next frame start and line-0 request occur on the first cycle after release.
- The FIFO must hold at least H_ACTIVE bytes; the loader has 408 blank cycles plus the active line to stay ahead.

Decomposition:
- Package vga_timing_pkg holds:
  - 1280x1024@60 timing constants (H_*/V_*, H_TOTAL, V_TOTAL, VBP0)
  - counter width localparam (11)
  - line-index width (13)
- Sub-module vga_timing_counter: h/v counters plus registered region flags (active, hs, vs, drain, req_point, frame_point).
- Top level owns FIFO pop, pixel register, request generator and sticky flags.

Test Plan:
- Release reset with FIFO empty:
  - 1st cycle: oFRAME_START=1, oLOAD_TO_FIFO_REQ=1 for exactly 4 cycles, oLINE_TO_LOAD=0.
  - HS period 1688 cycles, VS period 1066 lines, VS high for 3 lines.
- Model loader fills 1280 bytes (value = column[7:0]) per request:
  - line 0 active shows RGB 0,1,..,255,0,.. with BLANK_N high for 1280 cycles.
  - Next request is line 1, at h_cnt=1280 of line 0.
- Loader withholds line 5:
  - line 5 RGB=0, oUNDERFLOW=1 and stays 1.
  - Line 6 displays normally.
- Loader writes 1290 bytes for line 1023:
  - 10 pops during lines 1024..1027, oSTALE=1.
  - Line 0 of the next frame is correctly aligned (first pixel 0).
- Check the request sequence across a frame: lines 1..1023 each requested once, in order, then line 0. No request at the end of line 1023.
- Assert iRST at v_cnt=500, h_cnt=700 with the request high:
  - all outputs return to reset values immediately.
  - After release, line-0 request and oFRAME_START reappear on the first cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and region flag type for the VGA scan-out stage.
package vga_timing_pkg;

  // 1280x1024@60 default timing
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 48;
  localparam int H_SYNC   = 112;
  localparam int H_BP     = 248;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 1024;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 38;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // first back-porch line: counters restart here so the frame begins with a line-0 request
  localparam int VBP0     = V_ACTIVE + V_FP + V_SYNC;

  localparam logic SYNC_POL = 1'b1;
  localparam int   REQ_LEN  = 4;

  localparam int CNT_W  = 11;
  localparam int LINE_W = 13;

  // region flags, registered alongside the counters they describe
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic drain;
    logic req_point;
    logic frame_point;
  } region_t;

endpackage

// File: rtl/vga_fifo_scanout_if.sv
// Read side of the show-ahead VGA FIFO.
interface vga_fifo_scanout_if;
  logic       empty;
  logic [7:0] rdata;
  logic       rdreq;

  modport master (input empty, input rdata, output rdreq);
  modport slave  (output empty, output rdata, input rdreq);
endinterface

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical position counters with region flags registered in step with them.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic             clock,
  input  logic             iRST,
  output logic [CNT_W-1:0] v_cnt,
  output region_t          rgn
);

  localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VA_M1  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VB0    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] h_cnt, h_nxt, v_nxt;

  function automatic region_t decode(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    region_t r;
    r.active      = (h < HA) && (v < VA);
    r.hs          = (h >= HS_LO) && (h < HS_HI);
    r.vs          = (v >= VS_LO) && (v < VB0);
    r.drain       = (v >= VA) && (v < VB0);
    r.req_point   = (h == HA) && (v < VA_M1);
    r.frame_point = (h == '0) && (v == VB0);
    return r;
  endfunction

  // next position: h wraps every line, v advances on h wrap
  always_comb begin
    h_nxt = (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST)
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
  end

  // counters and flags; reset parks on the first back-porch line
  always_ff @(posedge clock or posedge iRST) begin
    if (iRST) begin
      h_cnt <= '0;
      v_cnt <= VB0;
      rgn   <= decode('0, VB0);
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      rgn   <= decode(h_nxt, v_nxt);
    end
  end

endmodule

// File: rtl/vga_fifo_scanout.sv
// Pixel-clock scan-out: pops the VGA FIFO, drives the DAC and issues line load requests.
module vga_fifo_scanout
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL,
  parameter int   REQ_LEN  = vga_timing_pkg::REQ_LEN
) (
  input  logic               clock,
  input  logic               iRST,
  vga_fifo_scanout_if.master fifo,
  output logic [LINE_W-1:0]  oLINE_TO_LOAD,
  output logic               oLOAD_TO_FIFO_REQ,
  output logic               oFRAME_START,
  output logic               oVGA_CLK,
  output logic [7:0]         oVGA_R,
  output logic [7:0]         oVGA_G,
  output logic [7:0]         oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_N,
  output logic               oVGA_SYNC_N,
  output logic               oUNDERFLOW,
  output logic               oSTALE
);

  localparam int RC_W = $clog2(REQ_LEN + 1);

  logic [CNT_W-1:0]  v_cnt;
  logic [CNT_W-1:0]  v_inc;
  region_t           rgn;
  logic              issue;
  logic [LINE_W-1:0] target;
  logic [RC_W-1:0]   req_cnt;
  logic [7:0]        pix;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clock (clock),
    .iRST  (iRST),
    .v_cnt (v_cnt),
    .rgn   (rgn)
  );

  // pop in active video, and flush leftovers between the last active line and line-0 load
  assign fifo.rdreq = !fifo.empty && (rgn.active || rgn.drain);

  assign v_inc = v_cnt + 1'b1;

  // pick the line to request: line 0 at frame start, otherwise the next line at h blank
  always_comb begin
    issue  = 1'b0;
    target = '0;
    if (rgn.frame_point) begin
      issue = 1'b1;
    end else if (rgn.req_point) begin
      issue  = 1'b1;
      target = {{(LINE_W-CNT_W){1'b0}}, v_inc};
    end
  end

  // video output register, request generator and sticky error flags
  always_ff @(posedge clock or posedge iRST) begin
    if (iRST) begin
      pix           <= '0;
      oVGA_HS       <= ~SYNC_POL;
      oVGA_VS       <= ~SYNC_POL;
      oVGA_BLANK_N  <= 1'b0;
      oFRAME_START  <= 1'b0;
      oLINE_TO_LOAD <= '0;
      req_cnt       <= '0;
      oUNDERFLOW    <= 1'b0;
      oSTALE        <= 1'b0;
    end else begin
      pix          <= (rgn.active && !fifo.empty) ? fifo.rdata : 8'h00;
      oVGA_HS      <= rgn.hs ? SYNC_POL : ~SYNC_POL;
      oVGA_VS      <= rgn.vs ? SYNC_POL : ~SYNC_POL;
      oVGA_BLANK_N <= rgn.active;
      oFRAME_START <= rgn.frame_point;
      if (issue) begin
        oLINE_TO_LOAD <= target;
        req_cnt       <= RC_W'(REQ_LEN);
      end else if (req_cnt != '0) begin
        req_cnt <= req_cnt - 1'b1;
      end
      oUNDERFLOW <= oUNDERFLOW | (rgn.active && fifo.empty);
      oSTALE     <= oSTALE | (fifo.rdreq && rgn.drain);
    end
  end

  assign oLOAD_TO_FIFO_REQ = (req_cnt != '0);
  assign oVGA_R      = pix;
  assign oVGA_G      = pix;
  assign oVGA_B      = pix;
  assign oVGA_CLK    = ~clock;
  assign oVGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_fifo_scanout.sv
// Bench for vga_fifo_scanout with shrunken timing; a position-based model checks every cycle.
module tb_vga_fifo_scanout;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSW = 3, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 25
  localparam int VT = VA + VFP + VSW + VBP;   // 14
  localparam int VB0 = VA + VFP + VSW;        // 12
  localparam int TOT = HT * VT;               // 350
  localparam int RL = 4;

  logic        clock = 1'b0;
  logic        iRST  = 1'b1;
  logic [12:0] oLINE_TO_LOAD;
  logic        oLOAD_TO_FIFO_REQ, oFRAME_START, oVGA_CLK;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oUNDERFLOW, oSTALE;

  vga_fifo_scanout_if fif ();

  always #5 clock = ~clock;

  vga_fifo_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SYNC_POL (1'b1), .REQ_LEN (RL)
  ) dut (
    .clock             (clock),
    .iRST              (iRST),
    .fifo              (fif),
    .oLINE_TO_LOAD     (oLINE_TO_LOAD),
    .oLOAD_TO_FIFO_REQ (oLOAD_TO_FIFO_REQ),
    .oFRAME_START      (oFRAME_START),
    .oVGA_CLK          (oVGA_CLK),
    .oVGA_R            (oVGA_R),
    .oVGA_G            (oVGA_G),
    .oVGA_B            (oVGA_B),
    .oVGA_HS           (oVGA_HS),
    .oVGA_VS           (oVGA_VS),
    .oVGA_BLANK_N      (oVGA_BLANK_N),
    .oVGA_SYNC_N       (oVGA_SYNC_N),
    .oUNDERFLOW        (oUNDERFLOW),
    .oSTALE            (oSTALE)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO contents, loader bookkeeping and model state
  logic [7:0] q[$];
  bit   run = 1'b0, phase1 = 1'b1;
  bit   pop_flag = 1'b0, prev_req = 1'b0, prev_hs = 1'b0;
  bit   uf_m = 1'b0, st_m = 1'b0;
  int   e = 0, last_issue = -100, exp_line = 0, leftover = 0, lf = -1;
  int   drain_pops = 0, vs_cnt = 0, ln;
  int   seq[$];
  int   hs_rise[$];
  logic [7:0] pin_pix = 8'h00;
  int   m, o, h, v, fn, tgt;
  bit   act, issue, fs_e;
  logic [7:0] exp_rgb;

  // what the DUT popped at each edge
  always @(posedge clock) pop_flag <= fif.rdreq;

  // FIFO/loader emulation plus per-cycle model comparison
  always @(negedge clock) begin
    if (pop_flag && q.size() > 0) void'(q.pop_front());

    if (oLOAD_TO_FIFO_REQ && !prev_req) begin
      ln = int'(oLINE_TO_LOAD);
      if (ln == 0) lf++;
      if (phase1) seq.push_back(ln);
      if (!(lf == 0 && ln == 5))
        for (int c = 0; c < HA; c++) q.push_back(8'((ln * 16 + c) & 255));
      if (lf == 0 && ln == VA - 1)
        repeat (10) q.push_back(8'hEE);
    end
    prev_req = oLOAD_TO_FIFO_REQ;

    if (run) begin
      e++;
      m  = e - 1;
      fn = m / TOT;
      o  = m % TOT;
      h  = o % HT;
      v  = (o / HT + VB0) % VT;
      act = (h < HA) && (v < VA);

      if (fn == 0 && v == VA - 1 && h == 0) leftover = 10;
      if (v >= VA && v < VB0 && leftover > 0) begin
        leftover--;
        st_m = 1'b1;
      end
      if (phase1 && pop_flag && v >= VA && v < VB0) drain_pops++;
      if (act && fn == 0 && v == 5) uf_m = 1'b1;

      if (!act || (fn == 0 && v == 5)) exp_rgb = 8'h00;
      else exp_rgb = 8'((v * 16 + h) & 255);

      issue = 1'b0;
      tgt   = 0;
      fs_e  = (h == 0 && v == VB0);
      if (fs_e) issue = 1'b1;
      else if (h == HA && v < VA - 1) begin
        issue = 1'b1;
        tgt   = v + 1;
      end
      if (issue) begin
        last_issue = e;
        exp_line   = tgt;
      end

      chk("rgb_r", oVGA_R, exp_rgb);
      chk("rgb_g", oVGA_G, exp_rgb);
      chk("rgb_b", oVGA_B, exp_rgb);
      chk("hs", oVGA_HS, 32'(h >= HA + HFP && h < HA + HFP + HSW));
      chk("vs", oVGA_VS, 32'(v >= VA + VFP && v < VB0));
      chk("blank_n", oVGA_BLANK_N, 32'(act));
      chk("frame_start", oFRAME_START, 32'(fs_e));
      chk("line_to_load", oLINE_TO_LOAD, exp_line);
      chk("load_req", oLOAD_TO_FIFO_REQ, 32'((e - last_issue) < RL));
      chk("underflow", oUNDERFLOW, 32'(uf_m));
      chk("stale", oSTALE, 32'(st_m));
      chk("vga_clk", oVGA_CLK, 1);
      chk("sync_n", oVGA_SYNC_N, 0);

      if (fn == 0 && v == 1 && h == 2) pin_pix = oVGA_R;
      if (phase1) begin
        if (oVGA_VS) vs_cnt++;
        if (oVGA_HS && !prev_hs) hs_rise.push_back(e);
      end
    end
    prev_hs = oVGA_HS;

    fif.empty = (q.size() == 0);
    fif.rdata = (q.size() > 0) ? q[0] : 8'h00;
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rgb"}, {oVGA_R, oVGA_G, oVGA_B}, 0);
    chk({tag, "_hs"}, oVGA_HS, 0);
    chk({tag, "_vs"}, oVGA_VS, 0);
    chk({tag, "_blank_n"}, oVGA_BLANK_N, 0);
    chk({tag, "_frame_start"}, oFRAME_START, 0);
    chk({tag, "_line"}, oLINE_TO_LOAD, 0);
    chk({tag, "_req"}, oLOAD_TO_FIFO_REQ, 0);
    chk({tag, "_underflow"}, oUNDERFLOW, 0);
    chk({tag, "_stale"}, oSTALE, 0);
    chk({tag, "_sync_n"}, oVGA_SYNC_N, 0);
  endtask

  initial begin
    int expv;
    fif.empty = 1'b1;
    fif.rdata = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    chk_reset_values("reset");

    // release with FIFO empty; first cycle carries frame start and line-0 request
    iRST = 1'b0;
    run  = 1'b1;
    @(negedge clock); #1;
    chk("first_frame_start", oFRAME_START, 1);
    chk("first_req", oLOAD_TO_FIFO_REQ, 1);
    chk("first_line", oLINE_TO_LOAD, 0);

    // run two full frames into the third, stopping at line 4 just after its request
    for (int i = 0; i < 2000 && e < 868; i++) begin
      @(negedge clock); #1;
    end
    chk("reached_reset_point", e, 868);
    chk("req_high_at_reset", oLOAD_TO_FIFO_REQ, 1);
    chk("pixel_line1_col2", pin_pix, 8'h12);
    chk("underflow_sticky", oUNDERFLOW, 1);
    chk("stale_sticky", oSTALE, 1);
    chk("drain_pops", drain_pops, 10);
    chk("vs_high_cycles", vs_cnt, 150);
    chk("hs_period", (hs_rise.size() >= 2) ? hs_rise[1] - hs_rise[0] : 0, 25);
    chk("req_count", seq.size(), 22);
    for (int i = 0; i < 22 && i < seq.size(); i++) begin
      expv = (i < 8) ? i : (i < 16) ? i - 8 : i - 16;
      chk("req_seq", seq[i], expv);
    end

    // mid-frame reset while the request is high
    run  = 1'b0;
    iRST = 1'b1;
    #1;
    chk_reset_values("midreset");
    chk("midreset_rdreq", fif.rdreq, 0);
    q.delete();
    fif.empty  = 1'b1;
    fif.rdata  = 8'h00;
    e          = 0;
    last_issue = -100;
    exp_line   = 0;
    uf_m       = 1'b0;
    st_m       = 1'b0;
    leftover   = 0;
    prev_req   = 1'b0;
    lf         = -1;
    phase1     = 1'b0;
    @(negedge clock);
    @(negedge clock); #1;
    iRST = 1'b0;
    run  = 1'b1;
    @(negedge clock); #1;
    chk("rerelease_frame_start", oFRAME_START, 1);
    chk("rerelease_req", oLOAD_TO_FIFO_REQ, 1);
    chk("rerelease_line", oLINE_TO_LOAD, 0);
    repeat (120) @(negedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
